// File: rtl/tomasulo_rsv_station_if.sv
// rtl/tomasulo_rsv_station_if.sv - dispatch, CDB snoop and issue bundle of the reservation station
//
// Purpose: carries every handshake/bus signal between the reservation station
//   and its surroundings (dispatch stage, common data buses, execution unit).
// Modports:
//   master - dispatch source + CDB drivers + execution unit
//            (drives disp_*, cdb_*, iss_rdy; observes disp_rdy, iss_*, occupancy)
//   slave  - the reservation station itself
// Signals:
//   disp_vld/disp_rdy, disp_op, disp_tag, disp_robid, disp_imm, disp_busy, disp_opr
//   cdb_vld, cdb_tag, cdb_wdata (CDB_N buses packed side by side, bus 0 in the low bits)
//   iss_vld/iss_rdy, iss_op, iss_tag, iss_robid, iss_imm, iss_rdata
//   occupancy (valid entries, excluding the issue register)
interface tomasulo_rsv_station_if #(
  parameter int N       = 4,
  parameter int W       = 32,
  parameter int TAG_W   = 5,
  parameter int ROBID_W = 5,
  parameter int OP_W    = 4,
  parameter int CDB_N   = 2
);
  localparam int OCC_W = $clog2(N + 1);

  logic                   disp_vld;
  logic                   disp_rdy;
  logic [OP_W-1:0]        disp_op;
  logic [TAG_W-1:0]       disp_tag;
  logic [ROBID_W-1:0]     disp_robid;
  logic [W-1:0]           disp_imm;
  logic [1:0]             disp_busy;
  logic [2*W-1:0]         disp_opr;

  logic [CDB_N-1:0]       cdb_vld;
  logic [CDB_N*TAG_W-1:0] cdb_tag;
  logic [CDB_N*W-1:0]     cdb_wdata;

  logic                   iss_vld;
  logic                   iss_rdy;
  logic [OP_W-1:0]        iss_op;
  logic [TAG_W-1:0]       iss_tag;
  logic [ROBID_W-1:0]     iss_robid;
  logic [W-1:0]           iss_imm;
  logic [2*W-1:0]         iss_rdata;

  logic [OCC_W-1:0]       occupancy;

  modport master (
    output disp_vld, disp_op, disp_tag, disp_robid, disp_imm, disp_busy, disp_opr,
    output cdb_vld, cdb_tag, cdb_wdata,
    output iss_rdy,
    input  disp_rdy, iss_vld, iss_op, iss_tag, iss_robid, iss_imm, iss_rdata, occupancy
  );

  modport slave (
    input  disp_vld, disp_op, disp_tag, disp_robid, disp_imm, disp_busy, disp_opr,
    input  cdb_vld, cdb_tag, cdb_wdata,
    input  iss_rdy,
    output disp_rdy, iss_vld, iss_op, iss_tag, iss_robid, iss_imm, iss_rdata, occupancy
  );
endinterface

// File: rtl/tomasulo_rsv_station.sv
// rtl/tomasulo_rsv_station.sv - Tomasulo reservation station with CDB wakeup and oldest-first issue
//
// Purpose: holds dispatched ops until both operands are resolved, snoops CDB_N
//   result buses to resolve pending operands by tag, and issues the oldest ready
//   op through a registered valid/ready stage.
// Ports:
//   clk    - clock, all state on rising edge
//   rst_n  - asynchronous active-low reset
//   flush  - synchronous discard of all entries and the issue register
//   bus    - tomasulo_rsv_station_if.slave (dispatch, CDB snoop, issue, occupancy)
module tomasulo_rsv_station #(
  parameter int N       = 4,
  parameter int W       = 32,
  parameter int TAG_W   = 5,
  parameter int ROBID_W = 5,
  parameter int OP_W    = 4,
  parameter int CDB_N   = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  tomasulo_rsv_station_if.slave bus
);
  localparam int OCC_W = $clog2(N + 1);
  localparam int IDX_W = $clog2(N);
  localparam logic [OCC_W-1:0] N_OCC = OCC_W'(N);

  // Entry storage
  logic [N-1:0]       vld_q, vld_d;
  logic [1:0]         busy_q  [N];
  logic [1:0]         busy_d  [N];
  logic [W-1:0]       opr_q   [N][2];
  logic [W-1:0]       opr_d   [N][2];
  logic [OP_W-1:0]    op_q    [N];
  logic [OP_W-1:0]    op_d    [N];
  logic [TAG_W-1:0]   tag_q   [N];
  logic [TAG_W-1:0]   tag_d   [N];
  logic [ROBID_W-1:0] robid_q [N];
  logic [ROBID_W-1:0] robid_d [N];
  logic [W-1:0]       imm_q   [N];
  logic [W-1:0]       imm_d   [N];
  // older_q[i][j] = 1 means entry j was dispatched before entry i
  logic [N-1:0]       older_q [N];
  logic [N-1:0]       older_d [N];

  // Issue register
  logic               iss_vld_q, iss_vld_d;
  logic [OP_W-1:0]    iss_op_q, iss_op_d;
  logic [TAG_W-1:0]   iss_tag_q, iss_tag_d;
  logic [ROBID_W-1:0] iss_robid_q, iss_robid_d;
  logic [W-1:0]       iss_imm_q, iss_imm_d;
  logic [2*W-1:0]     iss_rdata_q, iss_rdata_d;

  logic [OCC_W-1:0]   occ_q, occ_d;

  logic [N-1:0]       rdy;
  logic [N-1:0]       gnt;
  logic               any_rdy;
  logic [IDX_W-1:0]   gnt_idx;
  logic [IDX_W-1:0]   alloc_idx;
  logic               disp_rdy;
  logic               disp_fire;
  logic               iss_load;

  // Readiness is taken from registered state only, so a wakeup captured at an
  // edge becomes issuable one cycle later.
  always_comb begin
    rdy       = '0;
    gnt       = '0;
    gnt_idx   = '0;
    alloc_idx = '0;
    for (int i = 0; i < N; i++) begin
      rdy[i] = vld_q[i] & (busy_q[i] == 2'b00);
    end
    // An entry wins when no older entry is also ready; the age matrix is a
    // strict order so at most one bit of gnt is set.
    for (int i = 0; i < N; i++) begin
      gnt[i] = rdy[i] & ~|(rdy & older_q[i]);
    end
    for (int i = N - 1; i >= 0; i--) begin
      if (gnt[i]) gnt_idx = IDX_W'(i);
      if (!vld_q[i]) alloc_idx = IDX_W'(i);
    end
    any_rdy = |rdy;
  end

  assign disp_rdy  = (occ_q < N_OCC) & ~flush;
  assign disp_fire = bus.disp_vld & disp_rdy;
  assign iss_load  = (~iss_vld_q | bus.iss_rdy) & any_rdy;

  always_comb begin
    vld_d       = vld_q;
    busy_d      = busy_q;
    opr_d       = opr_q;
    op_d        = op_q;
    tag_d       = tag_q;
    robid_d     = robid_q;
    imm_d       = imm_q;
    older_d     = older_q;
    iss_vld_d   = iss_vld_q;
    iss_op_d    = iss_op_q;
    iss_tag_d   = iss_tag_q;
    iss_robid_d = iss_robid_q;
    iss_imm_d   = iss_imm_q;
    iss_rdata_d = iss_rdata_q;
    occ_d       = occ_q + OCC_W'(disp_fire) - OCC_W'(iss_load);

    // Wakeup: buses scanned from the top down so the lowest index match wins.
    for (int i = 0; i < N; i++) begin
      for (int k = 0; k < 2; k++) begin
        if (vld_q[i] && busy_q[i][k]) begin
          for (int b = CDB_N - 1; b >= 0; b--) begin
            if (bus.cdb_vld[b] && (bus.cdb_tag[b*TAG_W +: TAG_W] == opr_q[i][k][TAG_W-1:0])) begin
              opr_d[i][k]  = bus.cdb_wdata[b*W +: W];
              busy_d[i][k] = 1'b0;
            end
          end
        end
      end
    end

    if (iss_load) begin
      vld_d[gnt_idx] = 1'b0;
      iss_vld_d      = 1'b1;
      iss_op_d       = op_q[gnt_idx];
      iss_tag_d      = tag_q[gnt_idx];
      iss_robid_d    = robid_q[gnt_idx];
      iss_imm_d      = imm_q[gnt_idx];
      iss_rdata_d    = {opr_q[gnt_idx][1], opr_q[gnt_idx][0]};
    end else if (bus.iss_rdy) begin
      iss_vld_d = 1'b0;
    end

    // The allocated slot was free in registered state, so it never collides
    // with the wakeup or issue updates above.
    if (disp_fire) begin
      vld_d[alloc_idx]   = 1'b1;
      op_d[alloc_idx]    = bus.disp_op;
      tag_d[alloc_idx]   = bus.disp_tag;
      robid_d[alloc_idx] = bus.disp_robid;
      imm_d[alloc_idx]   = bus.disp_imm;
      for (int k = 0; k < 2; k++) begin
        opr_d[alloc_idx][k]  = bus.disp_opr[k*W +: W];
        busy_d[alloc_idx][k] = bus.disp_busy[k];
        if (bus.disp_busy[k]) begin
          for (int b = CDB_N - 1; b >= 0; b--) begin
            if (bus.cdb_vld[b] && (bus.cdb_tag[b*TAG_W +: TAG_W] == bus.disp_opr[k*W +: TAG_W])) begin
              opr_d[alloc_idx][k]  = bus.cdb_wdata[b*W +: W];
              busy_d[alloc_idx][k] = 1'b0;
            end
          end
        end
      end
      // Newcomer is younger than every entry currently held.
      for (int i = 0; i < N; i++) begin
        older_d[i][alloc_idx] = 1'b0;
      end
      older_d[alloc_idx] = vld_q;
    end

    if (flush) begin
      vld_d     = '0;
      iss_vld_d = 1'b0;
      occ_d     = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      for (int i = 0; i < N; i++) begin
        busy_q[i]   <= '0;
        opr_q[i][0] <= '0;
        opr_q[i][1] <= '0;
        op_q[i]     <= '0;
        tag_q[i]    <= '0;
        robid_q[i]  <= '0;
        imm_q[i]    <= '0;
        older_q[i]  <= '0;
      end
      iss_vld_q   <= 1'b0;
      iss_op_q    <= '0;
      iss_tag_q   <= '0;
      iss_robid_q <= '0;
      iss_imm_q   <= '0;
      iss_rdata_q <= '0;
      occ_q       <= '0;
    end else begin
      vld_q       <= vld_d;
      busy_q      <= busy_d;
      opr_q       <= opr_d;
      op_q        <= op_d;
      tag_q       <= tag_d;
      robid_q     <= robid_d;
      imm_q       <= imm_d;
      older_q     <= older_d;
      iss_vld_q   <= iss_vld_d;
      iss_op_q    <= iss_op_d;
      iss_tag_q   <= iss_tag_d;
      iss_robid_q <= iss_robid_d;
      iss_imm_q   <= iss_imm_d;
      iss_rdata_q <= iss_rdata_d;
      occ_q       <= occ_d;
    end
  end

  assign bus.disp_rdy  = disp_rdy;
  assign bus.iss_vld   = iss_vld_q;
  assign bus.iss_op    = iss_op_q;
  assign bus.iss_tag   = iss_tag_q;
  assign bus.iss_robid = iss_robid_q;
  assign bus.iss_imm   = iss_imm_q;
  assign bus.iss_rdata = iss_rdata_q;
  assign bus.occupancy = occ_q;
endmodule

// File: tb/tb_tomasulo_rsv_station.sv
// tb/tb_tomasulo_rsv_station.sv - directed self-checking bench for tomasulo_rsv_station
//
// Purpose: drives dispatch, CDB and issue handshakes through the station
//   interface and compares issue outputs against hand-computed values.
// Ports: none (top-level bench).
module tb_tomasulo_rsv_station;
  logic clk = 1'b0;
  logic rst_n;
  logic flush;
  int   total = 0;
  int   bad   = 0;

  tomasulo_rsv_station_if bus ();

  tomasulo_rsv_station dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  // Two buses carrying the same tag in one cycle is illegal stimulus.
  always @(posedge clk) begin
    if (rst_n && bus.cdb_vld == 2'b11)
      assert (bus.cdb_tag[4:0] != bus.cdb_tag[9:5]) else $error("duplicate cdb tag");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_disp();
    bus.disp_vld   = 1'b0;
    bus.disp_op    = '0;
    bus.disp_tag   = '0;
    bus.disp_robid = '0;
    bus.disp_imm   = '0;
    bus.disp_busy  = '0;
    bus.disp_opr   = '0;
  endtask

  task automatic idle_cdb();
    bus.cdb_vld   = '0;
    bus.cdb_tag   = '0;
    bus.cdb_wdata = '0;
  endtask

  task automatic disp(input logic [3:0] op, input logic [4:0] tag, input logic [4:0] robid,
                      input logic [1:0] busy, input logic [31:0] opr1, input logic [31:0] opr0);
    bus.disp_vld   = 1'b1;
    bus.disp_op    = op;
    bus.disp_tag   = tag;
    bus.disp_robid = robid;
    bus.disp_imm   = 32'h1000 + 32'(tag);
    bus.disp_busy  = busy;
    bus.disp_opr   = {opr1, opr0};
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    flush = 1'b0;
    bus.iss_rdy = 1'b1;
    idle_disp();
    idle_cdb();
    step();
    step();
    total++; if (bus.iss_vld !== 1'b0) begin bad++; $display("FAIL reset_iss_vld got=%0d exp=0", bus.iss_vld); end
    total++; if (bus.occupancy !== 3'd0) begin bad++; $display("FAIL reset_occ got=%0d exp=0", bus.occupancy); end
    total++; if (bus.iss_rdata !== 64'd0) begin bad++; $display("FAIL reset_rdata got=%0h exp=0", bus.iss_rdata); end
    rst_n = 1'b1;
    #1;
    total++; if (bus.disp_rdy !== 1'b1) begin bad++; $display("FAIL reset_disp_rdy got=%0d exp=1", bus.disp_rdy); end
    step();
  endtask

  task automatic test_basic();
    disp(4'd1, 5'd1, 5'd2, 2'b00, 32'd7, 32'd5);
    step();
    idle_disp();
    total++; if (bus.occupancy !== 3'd1) begin bad++; $display("FAIL basic_occ1 got=%0d exp=1", bus.occupancy); end
    total++; if (bus.iss_vld !== 1'b0) begin bad++; $display("FAIL basic_early_vld got=%0d exp=0", bus.iss_vld); end
    step();
    total++; if (bus.iss_vld !== 1'b1) begin bad++; $display("FAIL basic_vld got=%0d exp=1", bus.iss_vld); end
    total++; if (bus.iss_rdata !== {32'd7, 32'd5}) begin bad++; $display("FAIL basic_rdata got=%0h exp=%0h", bus.iss_rdata, {32'd7, 32'd5}); end
    total++; if (bus.iss_op !== 4'd1 || bus.iss_robid !== 5'd2) begin bad++; $display("FAIL basic_op_robid got=%0d/%0d exp=1/2", bus.iss_op, bus.iss_robid); end
    total++; if (bus.iss_imm !== 32'h1001) begin bad++; $display("FAIL basic_imm got=%0h exp=1001", bus.iss_imm); end
    total++; if (bus.occupancy !== 3'd0) begin bad++; $display("FAIL basic_occ0 got=%0d exp=0", bus.occupancy); end
    step();
    total++; if (bus.iss_vld !== 1'b0) begin bad++; $display("FAIL basic_drop got=%0d exp=0", bus.iss_vld); end
  endtask

  task automatic test_cdb_wakeup();
    disp(4'd2, 5'd4, 5'd3, 2'b01, 32'h11, 32'd3);
    step();
    idle_disp();
    step();
    total++; if (bus.iss_vld !== 1'b0) begin bad++; $display("FAIL wake_wait got=%0d exp=0", bus.iss_vld); end
    bus.cdb_vld   = 2'b10;
    bus.cdb_tag   = {5'd3, 5'd0};
    bus.cdb_wdata = {32'hAA, 32'h0};
    step();
    idle_cdb();
    total++; if (bus.iss_vld !== 1'b0) begin bad++; $display("FAIL wake_t1 got=%0d exp=0", bus.iss_vld); end
    step();
    total++; if (bus.iss_vld !== 1'b1 || bus.iss_tag !== 5'd4) begin bad++; $display("FAIL wake_issue got=%0d/%0d exp=1/4", bus.iss_vld, bus.iss_tag); end
    total++; if (bus.iss_rdata !== {32'h11, 32'hAA}) begin bad++; $display("FAIL wake_rdata got=%0h exp=%0h", bus.iss_rdata, {32'h11, 32'hAA}); end
    step();
  endtask

  task automatic test_bypass();
    disp(4'd3, 5'd5, 5'd4, 2'b10, 32'd9, 32'h22);
    bus.cdb_vld   = 2'b01;
    bus.cdb_tag   = {5'd0, 5'd9};
    bus.cdb_wdata = {32'h0, 32'h55};
    step();
    idle_disp();
    idle_cdb();
    total++; if (bus.occupancy !== 3'd1 || bus.iss_vld !== 1'b0) begin bad++; $display("FAIL byp_t1 got=%0d/%0d exp=1/0", bus.occupancy, bus.iss_vld); end
    step();
    total++; if (bus.iss_vld !== 1'b1) begin bad++; $display("FAIL byp_vld got=%0d exp=1", bus.iss_vld); end
    total++; if (bus.iss_rdata !== {32'h55, 32'h22}) begin bad++; $display("FAIL byp_rdata got=%0h exp=%0h", bus.iss_rdata, {32'h55, 32'h22}); end
    step();
  endtask

  task automatic test_age_order();
    logic [4:0]  wtag [4] = '{5'd10, 5'd12, 5'd10, 5'd11};
    logic [4:0]  etag [4] = '{5'd20, 5'd22, 5'd23, 5'd24};
    logic [31:0] eop0 [4] = '{32'hA0, 32'hA0, 32'hB0, 32'hB0};
    logic [31:0] eop1 [4] = '{32'd0, 32'd2, 32'd3, 32'd4};
    for (int i = 0; i < 4; i++) begin
      disp(4'd4, 5'(20 + i), 5'(i), 2'b01, 32'(i), 32'(wtag[i]));
      step();
    end
    idle_disp();
    total++; if (bus.occupancy !== 3'd4) begin bad++; $display("FAIL age_full_occ got=%0d exp=4", bus.occupancy); end
    total++; if (bus.disp_rdy !== 1'b0) begin bad++; $display("FAIL age_full_rdy got=%0d exp=0", bus.disp_rdy); end
    disp(4'd4, 5'd30, 5'd0, 2'b00, 32'd0, 32'd0);
    step();
    idle_disp();
    total++; if (bus.occupancy !== 3'd4 || bus.iss_vld !== 1'b0) begin bad++; $display("FAIL age_ignored got=%0d/%0d exp=4/0", bus.occupancy, bus.iss_vld); end
    // wake only slot 1 so it issues and frees a low-index slot
    bus.cdb_vld   = 2'b01;
    bus.cdb_tag   = {5'd0, 5'd12};
    bus.cdb_wdata = {32'h0, 32'hC1};
    step();
    idle_cdb();
    step();
    total++; if (bus.iss_vld !== 1'b1 || bus.iss_tag !== 5'd21) begin bad++; $display("FAIL age_first got=%0d/%0d exp=1/21", bus.iss_vld, bus.iss_tag); end
    total++; if (bus.iss_rdata !== {32'd1, 32'hC1} || bus.occupancy !== 3'd3) begin bad++; $display("FAIL age_first_data got=%0h/%0d exp=1000000c1/3", bus.iss_rdata, bus.occupancy); end
    // the youngest op lands in the freed slot 1
    disp(4'd4, 5'd24, 5'd9, 2'b01, 32'd4, 32'd11);
    step();
    idle_disp();
    bus.cdb_vld   = 2'b11;
    bus.cdb_tag   = {5'd10, 5'd11};
    bus.cdb_wdata = {32'hA0, 32'hB0};
    step();
    idle_cdb();
    for (int j = 0; j < 4; j++) begin
      step();
      total++; if (bus.iss_vld !== 1'b1 || bus.iss_tag !== etag[j]) begin bad++; $display("FAIL age_order%0d got=%0d/%0d exp=1/%0d", j, bus.iss_vld, bus.iss_tag, etag[j]); end
      total++; if (bus.iss_rdata !== {eop1[j], eop0[j]}) begin bad++; $display("FAIL age_rdata%0d got=%0h exp=%0h", j, bus.iss_rdata, {eop1[j], eop0[j]}); end
    end
    step();
    total++; if (bus.iss_vld !== 1'b0 || bus.occupancy !== 3'd0) begin bad++; $display("FAIL age_empty got=%0d/%0d exp=0/0", bus.iss_vld, bus.occupancy); end
  endtask

  task automatic test_back_to_back();
    bus.iss_rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      disp(4'd5, 5'(40 + i), 5'(i), 2'b00, 32'h100 + 32'(i), 32'h200 + 32'(i));
      step();
    end
    idle_disp();
    for (int c = 0; c < 5; c++) begin
      total++; if (bus.iss_vld !== 1'b1 || bus.iss_tag !== 5'd40) begin bad++; $display("FAIL stall%0d got=%0d/%0d exp=1/40", c, bus.iss_vld, bus.iss_tag); end
      total++; if (bus.iss_rdata !== {32'h100, 32'h200}) begin bad++; $display("FAIL stall_data%0d got=%0h exp=%0h", c, bus.iss_rdata, {32'h100, 32'h200}); end
      step();
    end
    total++; if (bus.occupancy !== 3'd2) begin bad++; $display("FAIL stall_occ got=%0d exp=2", bus.occupancy); end
    bus.iss_rdy = 1'b1;
    step();
    total++; if (bus.iss_vld !== 1'b1 || bus.iss_tag !== 5'd41) begin bad++; $display("FAIL drain1 got=%0d/%0d exp=1/41", bus.iss_vld, bus.iss_tag); end
    step();
    total++; if (bus.iss_vld !== 1'b1 || bus.iss_tag !== 5'd42) begin bad++; $display("FAIL drain2 got=%0d/%0d exp=1/42", bus.iss_vld, bus.iss_tag); end
    total++; if (bus.iss_rdata !== {32'h102, 32'h202}) begin bad++; $display("FAIL drain2_data got=%0h exp=%0h", bus.iss_rdata, {32'h102, 32'h202}); end
    step();
    total++; if (bus.iss_vld !== 1'b0 || bus.occupancy !== 3'd0) begin bad++; $display("FAIL drain_end got=%0d/%0d exp=0/0", bus.iss_vld, bus.occupancy); end
  endtask

  task automatic test_flush_reset();
    bus.iss_rdy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      disp(4'd6, 5'(50 + i), 5'(i), 2'b00, 32'(i), 32'(i));
      step();
    end
    idle_disp();
    total++; if (bus.occupancy !== 3'd4 || bus.iss_vld !== 1'b1) begin bad++; $display("FAIL fl_full got=%0d/%0d exp=4/1", bus.occupancy, bus.iss_vld); end
    flush = 1'b1;
    disp(4'd6, 5'd60, 5'd0, 2'b00, 32'd1, 32'd1);
    step();
    flush = 1'b0;
    idle_disp();
    total++; if (bus.occupancy !== 3'd0 || bus.iss_vld !== 1'b0) begin bad++; $display("FAIL fl_clear got=%0d/%0d exp=0/0", bus.occupancy, bus.iss_vld); end
    // flush on an empty station must still drop the dispatch
    bus.iss_rdy = 1'b1;
    flush = 1'b1;
    disp(4'd6, 5'd61, 5'd0, 2'b00, 32'd1, 32'd1);
    #1;
    total++; if (bus.disp_rdy !== 1'b0) begin bad++; $display("FAIL fl_rdy got=%0d exp=0", bus.disp_rdy); end
    step();
    flush = 1'b0;
    idle_disp();
    step();
    step();
    total++; if (bus.iss_vld !== 1'b0 || bus.occupancy !== 3'd0) begin bad++; $display("FAIL fl_lost got=%0d/%0d exp=0/0", bus.iss_vld, bus.occupancy); end
    // async reset in the middle of a drain
    for (int i = 0; i < 3; i++) begin
      disp(4'd7, 5'(70 + i), 5'(i), 2'b00, 32'hF0, 32'hF1);
      step();
    end
    idle_disp();
    total++; if (bus.iss_vld !== 1'b1 || bus.iss_tag !== 5'd71) begin bad++; $display("FAIL rst_pre got=%0d/%0d exp=1/71", bus.iss_vld, bus.iss_tag); end
    #2;
    rst_n = 1'b0;
    #1;
    total++; if (bus.iss_vld !== 1'b0 || bus.occupancy !== 3'd0) begin bad++; $display("FAIL rst_mid got=%0d/%0d exp=0/0", bus.iss_vld, bus.occupancy); end
    total++; if (bus.iss_rdata !== 64'd0 || bus.iss_tag !== 5'd0) begin bad++; $display("FAIL rst_mid_data got=%0h/%0d exp=0/0", bus.iss_rdata, bus.iss_tag); end
    @(negedge clk);
    rst_n = 1'b1;
    step();
    total++; if (bus.disp_rdy !== 1'b1 || bus.iss_vld !== 1'b0) begin bad++; $display("FAIL rst_after got=%0d/%0d exp=1/0", bus.disp_rdy, bus.iss_vld); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_cdb_wakeup();
    test_bypass();
    test_age_order();
    test_back_to_back();
    test_flush_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
